// File: rtl/vregfile_inc_pkg.sv
// Shared constants for the multi-read-port inc register file: FSM state codes,
// per-port read-source select encoding and the supported read-port ceiling.
package vregfile_inc_pkg;

    localparam int MAXRDPORTS = 4;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    localparam logic [1:0] RSEL_MEM  = 2'd0;
    localparam logic [1:0] RSEL_BYP  = 2'd1;
    localparam logic [1:0] RSEL_ZERO = 2'd2;

    // Zero (reg0 or sweep in progress) outranks the same-edge write bypass.
    function automatic logic [1:0] rd_sel(input logic zero, input logic hit);
        return zero ? RSEL_ZERO : (hit ? RSEL_BYP : RSEL_MEM);
    endfunction

endpackage

// File: rtl/vregfile_inc_mp_if.sv
// Handshake bundle for vregfile_inc_mp: packed per-port read buses, write bus, clear control.
// master drives requests, slave (the register file) returns read data and busy.
interface vregfile_inc_mp_if #(
    parameter int WIDTH       = 32,
    parameter int NUMREGS     = 8,
    parameter int LOG2NUMREGS = 3,
    parameter int NUMRDPORTS  = 2
);
    logic [NUMRDPORTS-1:0]             rd_en;
    logic [NUMRDPORTS*LOG2NUMREGS-1:0] rd_reg;
    logic [NUMRDPORTS*WIDTH-1:0]       rd_data;
    logic [LOG2NUMREGS-1:0]            c_reg;
    logic [WIDTH-1:0]                  c_writedatain;
    logic                              c_we;
    logic                              clr_start;
    logic                              busy;

    modport master (
        output rd_en, rd_reg, c_reg, c_writedatain, c_we, clr_start,
        input  rd_data, busy
    );

    modport slave (
        input  rd_en, rd_reg, c_reg, c_writedatain, c_we, clr_start,
        output rd_data, busy
    );
endinterface

// File: rtl/vregfile_inc_bank.sv
// Purpose: one storage copy with a single write port and one registered read port.
// Latency: read data 1 cycle after an rd_en edge; writes visible to the next captured read.
// Backpressure: none; rd_en low holds rd_data. Bypass under VREGFILE_INC_BYPASS_EN.
module vregfile_inc_bank
    import vregfile_inc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUMREGS     = 8,
    parameter int LOG2NUMREGS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [LOG2NUMREGS-1:0] waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   busy,
    input  logic                   rd_en,
    input  logic [LOG2NUMREGS-1:0] rd_reg,
    output logic [WIDTH-1:0]       rd_data
);
    logic [WIDTH-1:0] mem [NUMREGS];
    logic             zero;
    logic             hit;
    logic [1:0]       sel;
    logic [WIDTH-1:0] rd_nxt;

    // RAM storage: deliberately unreset, the sweep sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        zero = busy || (rd_reg == '0);
`ifdef VREGFILE_INC_BYPASS_EN
        hit  = we && (waddr == rd_reg);
`else
        hit  = 1'b0;
`endif
        sel  = rd_sel(zero, hit);
        case (sel)
            RSEL_ZERO: rd_nxt = '0;
            RSEL_BYP:  rd_nxt = wdata;
            default:   rd_nxt = mem[rd_reg];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_nxt;
        end
    end
endmodule

// File: rtl/vregfile_inc_mp.sv
// Purpose: NUMRDPORTS-read / 1-write inc register file with a clear sweep; reg0 reads zero.
// Latency: reads 1 cycle, writes 1 cycle, sweep NUMREGS-1 cycles with busy high.
// Backpressure: writes dropped while busy; bypass build selected by VREGFILE_INC_BYPASS_EN.
module vregfile_inc_mp
    import vregfile_inc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUMREGS     = 8,
    parameter int LOG2NUMREGS = 3,
    parameter int NUMRDPORTS  = 2
) (
    input  logic               clk,
    input  logic               resetn,
    vregfile_inc_mp_if.slave   bus
);
    logic [0:0]             state;
    logic [LOG2NUMREGS-1:0] cnt;
    logic                   busy;
    logic                   wr_we;
    logic [LOG2NUMREGS-1:0] wr_addr;
    logic [WIDTH-1:0]       wr_data;
    logic [NUMRDPORTS*WIDTH-1:0] rd_data_all;

    assign busy     = (state == ST_CLEAR);
    assign bus.busy = busy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_CLEAR;
            cnt   <= LOG2NUMREGS'(1);
        end else begin
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + LOG2NUMREGS'(1);
                    if (cnt == LOG2NUMREGS'(NUMREGS - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (bus.clr_start) begin
                        state <= ST_CLEAR;
                        cnt   <= LOG2NUMREGS'(1);
                    end
                end
            endcase
        end
    end

    // The sweep owns the shared write bus while busy; user writes to reg0 are discarded.
    always_comb begin
        wr_we   = busy || (bus.c_we && (bus.c_reg != '0));
        wr_addr = busy ? cnt : bus.c_reg;
        wr_data = busy ? '0  : bus.c_writedatain;
    end

    for (genvar p = 0; p < NUMRDPORTS; p++) begin : g_bank
        vregfile_inc_bank #(
            .WIDTH       (WIDTH),
            .NUMREGS     (NUMREGS),
            .LOG2NUMREGS (LOG2NUMREGS)
        ) u_bank (
            .clk     (clk),
            .rst_n   (resetn),
            .we      (wr_we),
            .waddr   (wr_addr),
            .wdata   (wr_data),
            .busy    (busy),
            .rd_en   (bus.rd_en[p]),
            .rd_reg  (bus.rd_reg[p*LOG2NUMREGS +: LOG2NUMREGS]),
            .rd_data (rd_data_all[p*WIDTH +: WIDTH])
        );
    end

    assign bus.rd_data = rd_data_all;
endmodule

// File: tb/tb_vregfile_inc_mp.sv
// Scoreboarded bench for vregfile_inc_mp: directed scenarios then random traffic
// against an array-level model of the register file.
module tb_vregfile_inc_mp;
    localparam int W  = 32;
    localparam int N  = 8;
    localparam int L  = 3;
    localparam int NP = 2;
`ifdef VREGFILE_INC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    vregfile_inc_mp_if #(.WIDTH(W), .NUMREGS(N), .LOG2NUMREGS(L), .NUMRDPORTS(NP)) bus ();

    vregfile_inc_mp #(.WIDTH(W), .NUMREGS(N), .LOG2NUMREGS(L), .NUMRDPORTS(NP)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: register contents and remaining sweep cycles.
    logic [W-1:0] mem_m [N];
    int           remaining = N - 1;
    logic [W-1:0] exp_q [NP][$];
    bit           busy_q[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP*L-1:0] rr2(input logic [L-1:0] a, input logic [L-1:0] b);
        return {b, a};
    endfunction

    task automatic step(input logic [NP-1:0] en, input logic [NP*L-1:0] rr, input logic we,
                        input logic [L-1:0] creg, input logic [W-1:0] wd, input logic clr);
        logic [L-1:0] idx;
        logic [W-1:0] e;
        bit           busy_m;
        @(negedge clk);
        resetn            = 1'b1;
        bus.rd_en         = en;
        bus.rd_reg        = rr;
        bus.c_we          = we;
        bus.c_reg         = creg;
        bus.c_writedatain = wd;
        bus.clr_start     = clr;
        busy_m = (remaining > 0);
        for (int p = 0; p < NP; p++) begin
            if (en[p]) begin
                idx = rr[p*L +: L];
                if (busy_m || idx == '0)            e = '0;
                else if (BYP && we && creg == idx)  e = wd;
                else                                e = mem_m[idx];
                exp_q[p].push_back(e);
            end
        end
        if (busy_m) begin
            remaining--;
            if (remaining == 0) begin
                for (int i = 0; i < N; i++) mem_m[i] = '0;
            end
        end else begin
            if (we && creg != '0) mem_m[creg] = wd;
            if (clr) remaining = N - 1;
        end
        busy_q.push_back(remaining > 0);
    endtask

    task automatic idle_inputs();
        bus.rd_en = '0; bus.rd_reg = '0; bus.c_we = 1'b0;
        bus.c_reg = '0; bus.c_writedatain = '0; bus.clr_start = 1'b0;
    endtask

    task automatic do_reset(input bit mid);
        if (mid) begin
            @(posedge clk);
            #3;
        end else begin
            @(negedge clk);
        end
        resetn = 1'b0;
        idle_inputs();
        #1;
        check("busy_in_reset", W'(bus.busy), W'(1));
        for (int p = 0; p < NP; p++)
            check($sformatf("rd_data_in_reset_p%0d", p), bus.rd_data[p*W +: W], '0);
        remaining = N - 1;
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops one expected value per port whenever that port captured a read.
    initial begin : monitor
        logic [NP-1:0] en_s;
        logic          rs;
        logic [W-1:0]  hold [NP];
        for (int p = 0; p < NP; p++) hold[p] = '0;
        forever begin
            @(posedge clk);
            en_s = bus.rd_en;
            rs   = resetn;
            #1;
            if (!rs) begin
                for (int p = 0; p < NP; p++) begin
                    hold[p] = '0;
                    check($sformatf("rd_data_reset_p%0d", p), bus.rd_data[p*W +: W], '0);
                end
            end else begin
                if (busy_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL busy_underflow: no expected busy value at %0t", $time);
                end else begin
                    check("busy", W'(bus.busy), W'(busy_q.pop_front()));
                end
                for (int p = 0; p < NP; p++) begin
                    if (en_s[p]) begin
                        if (exp_q[p].size() == 0) begin
                            tests++; fails++;
                            $display("FAIL rd_underflow_p%0d: no expected read at %0t", p, $time);
                        end else begin
                            hold[p] = exp_q[p].pop_front();
                        end
                    end
                    check($sformatf("rd_data_p%0d", p), bus.rd_data[p*W +: W], hold[p]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) mem_m[i] = '0;
        idle_inputs();
        #1 resetn = 1'b0;
        do_reset(0);

        // Sweep after reset, reads during busy, then every index on both ports.
        for (int i = 0; i < N - 1; i++) step(2'b11, rr2(L'(i + 1), L'(6 - i)), 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < N; i++)     step(2'b11, rr2(L'(i), L'(7 - i)), 1'b0, '0, '0, 1'b0);

        // Basic write/read and reg0 write suppression.
        step(2'b00, '0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0);
        step(2'b11, rr2(3'd3, 3'd3), 1'b0, '0, '0, 1'b0);
        step(2'b11, rr2(3'd0, 3'd0), 1'b1, 3'd0, 32'h00001234, 1'b0);
        step(2'b11, rr2(3'd0, 3'd0), 1'b0, '0, '0, 1'b0);

        // Same-edge write and read.
        step(2'b00, '0, 1'b1, 3'd5, 32'h11111111, 1'b0);
        step(2'b11, rr2(3'd5, 3'd5), 1'b1, 3'd5, 32'hA5A5A5A5, 1'b0);
        step(2'b11, rr2(3'd5, 3'd5), 1'b0, '0, '0, 1'b0);

        // rd_en hold on port 1.
        step(2'b00, '0, 1'b1, 3'd2, 32'h5, 1'b0);
        step(2'b11, rr2(3'd2, 3'd2), 1'b0, '0, '0, 1'b0);
        step(2'b01, rr2(3'd2, 3'd2), 1'b1, 3'd2, 32'h9, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b01, rr2(3'd2, 3'd2), 1'b0, '0, '0, 1'b0);
        step(2'b10, rr2(3'd2, 3'd2), 1'b0, '0, '0, 1'b0);

        // Fill, clear, dropped write while busy, ignored clr_start mid-sweep.
        for (int i = 1; i < N; i++) step(2'b00, '0, 1'b1, L'(i), 32'h10000000 + i, 1'b0);
        step(2'b00, '0, 1'b1, 3'd6, 32'hCAFEF00D, 1'b1);
        step(2'b11, rr2(3'd1, 3'd6), 1'b1, 3'd4, 32'h0000FFFF, 1'b0);
        step(2'b00, '0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) step(2'b11, rr2(3'd4, 3'd6), 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < N; i++) step(2'b11, rr2(L'(i), L'(7 - i)), 1'b0, '0, '0, 1'b0);

        // Reset in the middle of a sweep.
        for (int i = 1; i < N; i++) step(2'b00, '0, 1'b1, L'(i), 32'h2000 + i, 1'b0);
        step(2'b11, rr2(3'd1, 3'd2), 1'b0, '0, '0, 1'b1);
        step(2'b00, '0, 1'b0, '0, '0, 1'b0);
        step(2'b00, '0, 1'b0, '0, '0, 1'b0);
        do_reset(1);
        for (int i = 0; i < N - 1; i++) step(2'b11, rr2(L'(i), L'(i + 1)), 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < N; i++)     step(2'b11, rr2(L'(i), L'(7 - i)), 1'b0, '0, '0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(NP'($urandom), (NP*L)'($urandom), 1'($urandom), L'($urandom), $urandom,
                 ($urandom_range(0, 29) == 0));
        end
        step(2'b00, '0, 1'b0, '0, '0, 1'b0);
        step(2'b00, '0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);

        for (int p = 0; p < NP; p++) begin
            tests++;
            if (exp_q[p].size() != 0) begin
                fails++;
                $display("FAIL rd_leftover_p%0d: %0d pending, expected 0", p, exp_q[p].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
